// File: rtl/scoreboard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scoreboard_ctrl_pkg
// Shared definitions for the issue scoreboard: register-file size, register
// index width, LC-3 style opcode constants and the branch FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package scoreboard_ctrl_pkg;

  localparam int NUM_RF = 16;
  localparam int IDX_W  = 4;

  // Opcode constants used by decode when classifying instructions
  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STW  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic {
    IDLE    = 1'b0,
    BR_WAIT = 1'b1
  } sb_state_t;

endpackage

// File: rtl/sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
// One per-register pending-write counter. Saturates at both ends; a decrement
// while already zero raises O_Underflow (combinational) and leaves the count at
// zero. Simultaneous increment and decrement leave the count unchanged.
// Ports:
//   I_CLOCK      clock
//   I_RESET      asynchronous active-high reset, clears the count
//   I_Inc        a write to this register was issued
//   I_Dec        a writeback to this register is occurring
//   O_Count      current pending-write count
//   O_Underflow  writeback arrived with no write pending
// -----------------------------------------------------------------------------
module sb_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic                 I_CLOCK,
  input  logic                 I_RESET,
  input  logic                 I_Inc,
  input  logic                 I_Dec,
  output logic [CNT_WIDTH-1:0] O_Count,
  output logic                 O_Underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  assign O_Underflow = I_Dec && (O_Count == '0);

  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      O_Count <= '0;
    end else if (I_Inc && !I_Dec && (O_Count != CNT_MAX)) begin
      O_Count <= O_Count + CNT_WIDTH'(1);
    end else if (I_Dec && !I_Inc && (O_Count != '0)) begin
      O_Count <= O_Count - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/scoreboard_ctrl.sv
// -----------------------------------------------------------------------------
// scoreboard_ctrl
// Issue-stage scoreboard: tracks in-flight register writes, blocks issue on
// RAW hazards (with same-cycle writeback forwarding) and on a full per-register
// write counter, and holds issue while a branch target is unresolved.
// Ports:
//   I_CLOCK, I_RESET            clock, asynchronous active-high reset
//   I_LOCK                      pipeline enable for issue-side changes
//   I_IssueValid                decode presents an instruction
//   I_SrcNIdx / I_SrcNUsed      source registers (N = 1..3) and read flags
//   I_DestIdx / I_DestWrite     destination register and write flag
//   I_IsBranch                  instruction is a control transfer
//   I_WriteBackEnable/RegIdx    writeback this cycle and its register
//   I_BranchResolved            outstanding branch target is known
//   O_IssueGrant                instruction issues this cycle (combinational)
//   O_DepStallSignal            data hazard blocks issue (combinational)
//   O_BranchStallSignal         branch outstanding (registered)
//   O_Error                     sticky: counter underflow or branch timeout
// -----------------------------------------------------------------------------
module scoreboard_ctrl #(
  parameter int NUM_RF     = scoreboard_ctrl_pkg::NUM_RF,
  parameter int CNT_WIDTH  = 2,
  parameter int BR_TIMEOUT = 15
) (
  input  logic                                I_CLOCK,
  input  logic                                I_RESET,
  input  logic                                I_LOCK,
  input  logic                                I_IssueValid,
  input  logic [scoreboard_ctrl_pkg::IDX_W-1:0] I_Src1Idx,
  input  logic [scoreboard_ctrl_pkg::IDX_W-1:0] I_Src2Idx,
  input  logic [scoreboard_ctrl_pkg::IDX_W-1:0] I_Src3Idx,
  input  logic                                I_Src1Used,
  input  logic                                I_Src2Used,
  input  logic                                I_Src3Used,
  input  logic [scoreboard_ctrl_pkg::IDX_W-1:0] I_DestIdx,
  input  logic                                I_DestWrite,
  input  logic                                I_IsBranch,
  input  logic                                I_WriteBackEnable,
  input  logic [scoreboard_ctrl_pkg::IDX_W-1:0] I_WriteBackRegIdx,
  input  logic                                I_BranchResolved,
  output logic                                O_IssueGrant,
  output logic                                O_DepStallSignal,
  output logic                                O_BranchStallSignal,
  output logic                                O_Error
);

  import scoreboard_ctrl_pkg::*;

  localparam int                   BRC_W   = $clog2(BR_TIMEOUT + 1);
  localparam logic [BRC_W-1:0]     BR_LAST = BRC_W'(BR_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  sb_state_t            state_q;
  logic [BRC_W-1:0]     br_cnt;
  logic [CNT_WIDTH-1:0] pend [NUM_RF];
  logic [NUM_RF-1:0]    underflow;
  logic                 src_haz;
  logic                 waw_haz;
  logic                 can_issue;

  // A pending source is still readable when its last outstanding write lands
  // this very cycle (writeback forwarding).
  function automatic logic src_hazard(input logic used,
                                      input logic [CNT_WIDTH-1:0] cnt,
                                      input logic wb_hit);
    return used && (cnt != '0) && !(wb_hit && (cnt == CNT_WIDTH'(1)));
  endfunction

  always_comb begin
    src_haz = src_hazard(I_Src1Used, pend[I_Src1Idx],
                         I_WriteBackEnable && (I_WriteBackRegIdx == I_Src1Idx))
            | src_hazard(I_Src2Used, pend[I_Src2Idx],
                         I_WriteBackEnable && (I_WriteBackRegIdx == I_Src2Idx))
            | src_hazard(I_Src3Used, pend[I_Src3Idx],
                         I_WriteBackEnable && (I_WriteBackRegIdx == I_Src3Idx));
    // A full counter can still accept a new write if one retires this cycle.
    waw_haz = I_DestWrite && (pend[I_DestIdx] == CNT_MAX)
            && !(I_WriteBackEnable && (I_WriteBackRegIdx == I_DestIdx));
  end

  assign can_issue        = I_LOCK && I_IssueValid && (state_q == IDLE);
  assign O_DepStallSignal = can_issue && (src_haz || waw_haz);
  assign O_IssueGrant     = can_issue && !(src_haz || waw_haz);

  // Per-register pending-write counters
  for (genvar r = 0; r < NUM_RF; r++) begin : g_pend
    sb_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .I_CLOCK     (I_CLOCK),
      .I_RESET     (I_RESET),
      .I_Inc       (O_IssueGrant && I_DestWrite && (I_DestIdx == IDX_W'(r))),
      .I_Dec       (I_WriteBackEnable && (I_WriteBackRegIdx == IDX_W'(r))),
      .O_Count     (pend[r]),
      .O_Underflow (underflow[r])
    );
  end

  // Branch FSM, wait counter and sticky error
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q             <= IDLE;
      br_cnt              <= '0;
      O_BranchStallSignal <= 1'b0;
      O_Error             <= 1'b0;
    end else begin
      if (|underflow) begin
        O_Error <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (O_IssueGrant && I_IsBranch) begin
            state_q             <= BR_WAIT;
            br_cnt              <= '0;
            O_BranchStallSignal <= 1'b1;
          end
        end
        BR_WAIT: begin
          if (I_BranchResolved) begin
            state_q             <= IDLE;
            O_BranchStallSignal <= 1'b0;
          end else if (br_cnt == BR_LAST) begin
            // Target never arrived: give up, flag it and reopen issue.
            state_q             <= IDLE;
            O_BranchStallSignal <= 1'b0;
            O_Error             <= 1'b1;
          end else begin
            br_cnt <= br_cnt + BRC_W'(1);
          end
        end
      endcase
    end
  end

endmodule
